lu_row_mem_ctrl: RTL and testbench
==================================

# lu_row_mem_ctrl

Row-store controller for the LU engine. It holds a SIZE×SIZE complex matrix as SIZE row-wide registers and sequences the whole job: host load, start of the `lu` datapath, service of the engine's row reads and row write-backs during factorisation, then host unload. It sits between the host/DMA side and the engine's `mat_row_*` ports, and arbitrates the single row-wide storage port per cycle.

## Interface
- `SIZE`, 16, matrix dimension (rows, and elements per row); power of two, ≥2
- `ELEM_W`, 128, element width, packed {imag, real} fp64
- `clk_i` in 1, clock
- `rst_ni` in 1, reset, asynchronous and active-low
- `flush_i` in 1, synchronous abort to IDLE
- `load_i` in 1, begin job (sampled in IDLE)
- `host_wr_valid_i` / `host_wr_ready_o` in/out 1, host row-write handshake
- `host_wr_addr_i` in $clog2(SIZE), host write row index
- `host_wr_row_i` in SIZE*ELEM_W, host write data
- `host_rd_valid_o` / `host_rd_ready_i` out/in 1, unload handshake
- `host_rd_addr_o` out $clog2(SIZE), unloaded row index
- `host_rd_row_o` out SIZE*ELEM_W, unloaded row data
- `start_o` out 1, one-cycle pulse to engine `start`
- `done_i` in 1, engine job-complete pulse
- `rd_req_addr_i` / `rd_req_valid_i` in, engine read request (`mat_row_read_addr_o/_valid_o`)
- `rd_row_o` / `rd_addr_o` / `rd_valid_o` out, read response to engine (`mat_row_i/_read_addr_i/_valid_i`)
- `wr_row_i` / `wr_addr_i` / `wr_valid_i` in, engine write-back
- `wr_ready_o` out 1, to engine `mat_row_out_ready_i`
- `rd_stall_cnt_o` out 16, saturating count of stalled engine read cycles
- `done_o` out 1, one-cycle pulse after last row unloaded

## Operation
- States: IDLE, LOAD, RUN, UNLOAD.
- IDLE → LOAD when `load_i`. The load counter and `rd_stall_cnt_o` clear on that transition.
- LOAD:
  - `host_wr_ready_o`=1. Each accepted write stores the row and increments the load counter.
  - When the counter reaches SIZE, the next state is RUN and `start_o` pulses for that one cycle.
  - Duplicate addresses count; the last write wins.
- RUN:
  - `wr_ready_o`=1. An engine write has priority over an engine read.
  - A read is granted when `rd_req_valid_i` and no write is accepted in the same cycle. Otherwise the read stalls and `rd_stall_cnt_o` increments, saturating at 0xFFFF.
- RUN → UNLOAD on `done_i`. A write accepted in the `done_i` cycle is still committed.
- UNLOAD:
  - Streams rows 0..SIZE-1 in order under valid/ready.
  - After row SIZE-1 is accepted, the next state is IDLE and `done_o` pulses.
- `flush_i`, in any state: next state IDLE, all counters and valids clear, no pulses. Storage contents are retained.
- Host ports are ignored outside LOAD/UNLOAD. Engine ports are ignored outside RUN.
- Address counters are $clog2(SIZE)+1 bits so that a count of SIZE is representable (no wrap to 0).

## Timing
- Reset value of every output is 0, with state IDLE. Storage is not reset.
- Host write: 0-latency accept. Data is visible to reads from the following cycle.
- Engine read latency is 1 cycle after the grant. `rd_valid_o` is a single-cycle pulse with `rd_addr_o` = the granted address and `rd_row_o` = stored row; all three are registered.
- A held `rd_req_valid_i` with a constant address yields one response per granted cycle. The engine ignores extras.
- `start_o` asserts in the first RUN cycle.
- Unload:
  - `host_rd_valid_o` rises 1 cycle after entering UNLOAD, with row 0.
  - While `!host_rd_ready_i`, address and data are held stable.
  - After an accept, the next row is presented the following cycle, so throughput is 1 row/cycle with ready held.
- `done_o` pulses in the first IDLE cycle.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous); the pending engine job is lost.

## Configuration
- `LU_ROW_MEM_FWD_EN` defined:
  - A read and a write to the same address in the same RUN cycle are both served.
  - The read response, one cycle later, carries `wr_row_i`; no stall is counted.
  - Different-address collisions still stall the read.
- Undefined: every read colliding with an accepted write stalls 1 cycle, per the priority rule.

## Test plan
- Load rows i=0..15 with every element = i → exactly 16 accepts, `start_o` single pulse in the next cycle, state RUN.
- RUN, read addr 3 → `rd_valid_o`=1 one cycle later with `rd_addr_o`=3 and all elements =3; `rd_stall_cnt_o`=0.
- RUN, write addr 5 (elements =0xAA) with a same-cycle read of addr 5:
  - Without the macro: read served next cycle, response 0xAA two cycles after request, `rd_stall_cnt_o`=1.
  - With the macro: response 0xAA one cycle after request, count 0.
- `done_i`, then `host_rd_ready_i` toggling 1,0,1,0… → rows 0..15 in order, each held while not ready, `done_o` pulses once, state IDLE.
- `flush_i` in LOAD after 7 rows → IDLE, no `start_o`. A new `load_i` requires 16 fresh writes.
- `rst_ni` low mid-RUN with a pending read → all outputs 0 immediately; after release, state IDLE and `rd_valid_o` stays 0.

Source files
------------

// File: rtl/lu_row_mem_ctrl.sv
// Row-store controller for the LU engine: host load, engine run service, host unload.
// Optional macro LU_ROW_MEM_FWD_EN forwards same-address write data to a colliding read.
module lu_row_mem_ctrl #(
  parameter int unsigned SIZE   = 16,
  parameter int unsigned ELEM_W = 128
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        load_i,
  input  logic                        host_wr_valid_i,
  output logic                        host_wr_ready_o,
  input  logic [$clog2(SIZE)-1:0]     host_wr_addr_i,
  input  logic [SIZE*ELEM_W-1:0]      host_wr_row_i,
  output logic                        host_rd_valid_o,
  input  logic                        host_rd_ready_i,
  output logic [$clog2(SIZE)-1:0]     host_rd_addr_o,
  output logic [SIZE*ELEM_W-1:0]      host_rd_row_o,
  output logic                        start_o,
  input  logic                        done_i,
  input  logic [$clog2(SIZE)-1:0]     rd_req_addr_i,
  input  logic                        rd_req_valid_i,
  output logic [SIZE*ELEM_W-1:0]      rd_row_o,
  output logic [$clog2(SIZE)-1:0]     rd_addr_o,
  output logic                        rd_valid_o,
  input  logic [SIZE*ELEM_W-1:0]      wr_row_i,
  input  logic [$clog2(SIZE)-1:0]     wr_addr_i,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  output logic [15:0]                 rd_stall_cnt_o,
  output logic                        done_o
);
  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned ROW_W = SIZE * ELEM_W;
  localparam logic [AW:0] LAST  = (AW+1)'(SIZE - 1);
  localparam logic [AW:0] FULL  = (AW+1)'(SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;

  state_t             state, state_n;
  logic [ROW_W-1:0]   mem [SIZE];
  logic [AW:0]        load_cnt, unload_cnt;
  logic               host_acc, eng_wr, fwd_hit, rd_grant, rd_stall;
  logic               unload_acc, unload_present, start_d, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (load_i) state_n = LOAD;
        LOAD:    if (host_acc && load_cnt == LAST) state_n = RUN;
        RUN:     if (done_i) state_n = UNLOAD;
        UNLOAD:  if (unload_acc && unload_cnt == FULL) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    host_wr_ready_o = (state == LOAD);
    wr_ready_o      = (state == RUN);
    host_acc        = host_wr_ready_o && host_wr_valid_i && !flush_i;
    eng_wr          = wr_ready_o && wr_valid_i && !flush_i;
`ifdef LU_ROW_MEM_FWD_EN
    fwd_hit         = eng_wr && rd_req_valid_i && (rd_req_addr_i == wr_addr_i);
`else
    fwd_hit         = 1'b0;
`endif
    rd_grant        = wr_ready_o && rd_req_valid_i && !flush_i && (!eng_wr || fwd_hit);
    rd_stall        = wr_ready_o && rd_req_valid_i && !flush_i && eng_wr && !fwd_hit;
    start_d         = host_acc && load_cnt == LAST;
    unload_acc      = (state == UNLOAD) && host_rd_valid_o && host_rd_ready_i && !flush_i;
    // a new row is presented when the slot is empty or the held row is being taken
    unload_present  = (state == UNLOAD) && !flush_i && unload_cnt != FULL &&
                      (!host_rd_valid_o || host_rd_ready_i);
    done_d          = unload_acc && unload_cnt == FULL;
  end

  always_ff @(posedge clk_i) begin
    if (host_acc)    mem[host_wr_addr_i] <= host_wr_row_i;
    else if (eng_wr) mem[wr_addr_i]      <= wr_row_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_cnt        <= '0;
      unload_cnt      <= '0;
      rd_stall_cnt_o  <= '0;
      start_o         <= 1'b0;
      done_o          <= 1'b0;
      rd_valid_o      <= 1'b0;
      rd_addr_o       <= '0;
      rd_row_o        <= '0;
      host_rd_valid_o <= 1'b0;
      host_rd_addr_o  <= '0;
      host_rd_row_o   <= '0;
    end else if (flush_i) begin
      load_cnt        <= '0;
      unload_cnt      <= '0;
      rd_stall_cnt_o  <= '0;
      start_o         <= 1'b0;
      done_o          <= 1'b0;
      rd_valid_o      <= 1'b0;
      host_rd_valid_o <= 1'b0;
    end else begin
      start_o    <= start_d;
      done_o     <= done_d;
      rd_valid_o <= rd_grant;
      if (rd_grant) begin
        rd_addr_o <= rd_req_addr_i;
        rd_row_o  <= fwd_hit ? wr_row_i : mem[rd_req_addr_i];
      end
      if (state == IDLE && load_i) begin
        load_cnt       <= '0;
        rd_stall_cnt_o <= '0;
      end
      if (host_acc) load_cnt <= load_cnt + 1'b1;
      if (rd_stall && rd_stall_cnt_o != '1) rd_stall_cnt_o <= rd_stall_cnt_o + 1'b1;
      if (state == RUN && done_i) unload_cnt <= '0;
      if (unload_present) begin
        host_rd_valid_o <= 1'b1;
        host_rd_addr_o  <= unload_cnt[AW-1:0];
        host_rd_row_o   <= mem[unload_cnt[AW-1:0]];
        unload_cnt      <= unload_cnt + 1'b1;
      end else if (unload_acc) begin
        host_rd_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lu_row_mem_ctrl.sv
// Directed bench for lu_row_mem_ctrl: load, engine read/write service, unload, flush, reset.
module tb_lu_row_mem_ctrl;
  localparam int unsigned SIZE   = 16;
  localparam int unsigned ELEM_W = 128;
  localparam int unsigned AW     = $clog2(SIZE);
  localparam int unsigned ROW_W  = SIZE * ELEM_W;

  logic              clk = 1'b0;
  logic              rst_n, flush, load;
  logic              host_wr_valid, host_wr_ready;
  logic [AW-1:0]     host_wr_addr;
  logic [ROW_W-1:0]  host_wr_row;
  logic              host_rd_valid, host_rd_ready;
  logic [AW-1:0]     host_rd_addr;
  logic [ROW_W-1:0]  host_rd_row;
  logic              start, done_in;
  logic [AW-1:0]     rd_req_addr;
  logic              rd_req_valid;
  logic [ROW_W-1:0]  rd_row;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid;
  logic [ROW_W-1:0]  wr_row;
  logic [AW-1:0]     wr_addr;
  logic              wr_valid, wr_ready;
  logic [15:0]       stall_cnt;
  logic              done_out;

  int checks = 0;
  int errors = 0;

  lu_row_mem_ctrl #(.SIZE(SIZE), .ELEM_W(ELEM_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .load_i(load),
    .host_wr_valid_i(host_wr_valid), .host_wr_ready_o(host_wr_ready),
    .host_wr_addr_i(host_wr_addr), .host_wr_row_i(host_wr_row),
    .host_rd_valid_o(host_rd_valid), .host_rd_ready_i(host_rd_ready),
    .host_rd_addr_o(host_rd_addr), .host_rd_row_o(host_rd_row),
    .start_o(start), .done_i(done_in),
    .rd_req_addr_i(rd_req_addr), .rd_req_valid_i(rd_req_valid),
    .rd_row_o(rd_row), .rd_addr_o(rd_addr), .rd_valid_o(rd_valid),
    .wr_row_i(wr_row), .wr_addr_i(wr_addr), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .rd_stall_cnt_o(stall_cnt), .done_o(done_out)
  );

  always #5 clk = ~clk;

  function automatic logic [ROW_W-1:0] fill(input logic [7:0] v);
    logic [ELEM_W-1:0] e;
    e = ELEM_W'(v);
    return {SIZE{e}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepts;
    int exp_idx;
    int done_cnt;
    int cyc;
    logic [7:0] v;

    rst_n = 1'b0; flush = 1'b0; load = 1'b0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_row = '0;
    host_rd_ready = 1'b0; done_in = 1'b0;
    rd_req_addr = '0; rd_req_valid = 1'b0;
    wr_row = '0; wr_addr = '0; wr_valid = 1'b0;
    #12;
    chk("rst_host_wr_ready", 32'(host_wr_ready), 0);
    chk("rst_host_rd_valid", 32'(host_rd_valid), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_done", 32'(done_out), 0);
    rst_n = 1'b1;
    tick();

    // load 16 rows, element value = row index
    load = 1'b1; tick(); load = 1'b0;
    chk("load_ready", 32'(host_wr_ready), 1);
    accepts = 0;
    for (int i = 0; i < 16; i++) begin
      host_wr_valid = 1'b1; host_wr_addr = AW'(i); host_wr_row = fill(8'(i));
      chk("load_no_start", 32'(start), 0);
      if (host_wr_ready) accepts++;
      tick();
    end
    host_wr_valid = 1'b0;
    chk("load_accepts", 32'(accepts), 16);
    chk("start_pulse", 32'(start), 1);
    chk("run_wr_ready", 32'(wr_ready), 1);
    chk("run_host_wr_ready", 32'(host_wr_ready), 0);
    tick();
    chk("start_single", 32'(start), 0);

    // plain read of row 3
    rd_req_valid = 1'b1; rd_req_addr = 3;
    tick();
    rd_req_valid = 1'b0;
    chk("rd3_valid", 32'(rd_valid), 1);
    chk("rd3_addr", 32'(rd_addr), 3);
    chk_row("rd3_row", rd_row, fill(8'd3));
    chk("rd3_stall", 32'(stall_cnt), 0);
    tick();
    chk("rd3_pulse_end", 32'(rd_valid), 0);

    // write 5 with same-cycle read of 5
    wr_valid = 1'b1; wr_addr = 5; wr_row = fill(8'hAA);
    rd_req_valid = 1'b1; rd_req_addr = 5;
    tick();
    wr_valid = 1'b0;
`ifdef LU_ROW_MEM_FWD_EN
    rd_req_valid = 1'b0;
    chk("col_valid", 32'(rd_valid), 1);
    chk("col_addr", 32'(rd_addr), 5);
    chk_row("col_row", rd_row, fill(8'hAA));
    chk("col_stall", 32'(stall_cnt), 0);
`else
    chk("col_stalled", 32'(rd_valid), 0);
    chk("col_stall1", 32'(stall_cnt), 1);
    tick();
    rd_req_valid = 1'b0;
    chk("col_valid", 32'(rd_valid), 1);
    chk("col_addr", 32'(rd_addr), 5);
    chk_row("col_row", rd_row, fill(8'hAA));
    chk("col_stall_hold", 32'(stall_cnt), 1);
`endif
    tick();

    // finish job, unload with ready toggling 1,0,1,0...
    done_in = 1'b1; tick(); done_in = 1'b0;
    chk("unl_first_invalid", 32'(host_rd_valid), 0);
    exp_idx = 0; done_cnt = 0; cyc = 0;
    while (exp_idx < 16 && cyc < 200) begin
      host_rd_ready = (cyc % 2 == 0);
      if (host_rd_valid) begin
        v = (exp_idx == 5) ? 8'hAA : 8'(exp_idx);
        chk("unl_addr", 32'(host_rd_addr), 32'(exp_idx));
        chk_row("unl_row", host_rd_row, fill(v));
        if (host_rd_ready) exp_idx++;
      end
      if (done_out) done_cnt++;
      tick();
      cyc++;
    end
    host_rd_ready = 1'b0;
    chk("unl_all_rows", 32'(exp_idx), 16);
    chk("unl_no_early_done", 32'(done_cnt), 0);
    chk("done_pulse", 32'(done_out), 1);
    chk("idle_rd_valid", 32'(host_rd_valid), 0);
    tick();
    chk("done_single", 32'(done_out), 0);
    chk("idle_wr_ready", 32'(wr_ready), 0);

    // flush in LOAD after 7 rows
    load = 1'b1; tick(); load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      host_wr_valid = 1'b1; host_wr_addr = AW'(i); host_wr_row = fill(8'(8'h40 + i));
      tick();
    end
    host_wr_valid = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_idle", 32'(host_wr_ready), 0);
    chk("flush_no_start", 32'(start), 0);
    tick();
    chk("flush_no_start2", 32'(start), 0);

    // fresh load needs all 16 writes
    load = 1'b1; tick(); load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      host_wr_valid = 1'b1; host_wr_addr = AW'(i); host_wr_row = fill(8'(8'h10 + i));
      tick();
    end
    chk("reload_15_no_start", 32'(start), 0);
    chk("reload_15_still_load", 32'(host_wr_ready), 1);
    host_wr_addr = 15; host_wr_row = fill(8'h1F);
    tick();
    host_wr_valid = 1'b0;
    chk("reload_start", 32'(start), 1);

    // asynchronous reset during RUN with an outstanding read
    rd_req_valid = 1'b1; rd_req_addr = 2;
    tick();
    chk("pre_rst_rd_valid", 32'(rd_valid), 1);
    chk_row("pre_rst_rd_row", rd_row, fill(8'h12));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_wr_ready", 32'(wr_ready), 0);
    chk("arst_rd_addr", 32'(rd_addr), 0);
    chk("arst_stall", 32'(stall_cnt), 0);
    rd_req_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_rd_valid", 32'(rd_valid), 0);
    chk("post_rst_idle", 32'(host_wr_ready), 0);
    chk("post_rst_wr_ready", 32'(wr_ready), 0);
    tick();
    chk("post_rst_rd_valid2", 32'(rd_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
